// File: rtl/serv_periph_pkg.sv
// Shared definitions for the SERV peripheral block: register map, CTRL bit
// positions and the byte-lane write merge used by every writable register.
package serv_periph_pkg;

    // Word offsets decoded from i_dbus_adr[4:2]; 5..7 are unmapped.
    typedef enum logic [2:0] {
        REG_GPIO_OUT = 3'd0,
        REG_GPIO_IN  = 3'd1,
        REG_MTIME    = 3'd2,
        REG_MTIMECMP = 3'd3,
        REG_CTRL     = 3'd4
    } reg_off_e;

    localparam int CTRL_TIMER_EN = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_W        = 2;

    // Replace only the byte lanes whose enable is set; callers truncate the
    // result to the register width, which discards bits above it.
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdat,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/serv_periph_timer.sv
// Machine timer: prescaler, mtime, mtimecmp and the registered level irq.
// Register read values are presented zero-extended to the 32-bit bus.
module serv_periph_timer
    import serv_periph_pkg::*;
#(
    parameter int TIMER_W  = 32,
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_irq_en,
    input  logic        i_mtime_we,
    input  logic        i_mtimecmp_we,
    input  logic [31:0] i_wdat,
    input  logic [3:0]  i_wsel,
    output logic [31:0] o_mtime,
    output logic [31:0] o_mtimecmp,
    output logic        o_irq
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [15:0]        presc;
    logic [TIMER_W-1:0] mtime;
    logic [TIMER_W-1:0] mtimecmp;
    logic [TIMER_W-1:0] mtime_nx;
    logic [TIMER_W-1:0] mtimecmp_nx;

    // Zero-extend for reads and build the byte-merged write values.
    always_comb begin
        o_mtime                   = '0;
        o_mtime[TIMER_W-1:0]      = mtime;
        o_mtimecmp                = '0;
        o_mtimecmp[TIMER_W-1:0]   = mtimecmp;
        mtime_nx    = TIMER_W'(merge_bytes(o_mtime, i_wdat, i_wsel));
        mtimecmp_nx = TIMER_W'(merge_bytes(o_mtimecmp, i_wdat, i_wsel));
    end

    // Prescaler and mtime: a bus write wins over a tick and restarts the
    // prescaler; otherwise count only while the timer is enabled.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            presc <= '0;
            mtime <= '0;
        end else if (i_mtime_we) begin
            presc <= '0;
            mtime <= mtime_nx;
        end else if (i_en) begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
                mtime <= mtime + TIMER_W'(1);
            end else begin
                presc <= presc + 16'd1;
            end
        end
    end

    // Compare register, reset to all ones so the irq cannot fire early.
    always_ff @(posedge clk) begin
        if (i_rst)              mtimecmp <= '1;
        else if (i_mtimecmp_we) mtimecmp <= mtimecmp_nx;
    end

    // Level irq registered from the current register state (one cycle lag).
    always_ff @(posedge clk) begin
        if (i_rst) o_irq <= 1'b0;
        else       o_irq <= i_irq_en && (mtime >= mtimecmp);
    end

endmodule

// File: rtl/serv_periph.sv
// SERV data-bus peripheral: address decode, GPIO in/out, CTRL register and a
// single-cycle acknowledge; the machine timer lives in serv_periph_timer.
module serv_periph
    import serv_periph_pkg::*;
#(
    parameter int GPIO_OUT_W = 3,
    parameter int GPIO_IN_W  = 1,
    parameter int OUT_INV    = 1,
    parameter int TIMER_W    = 32,
    parameter int PRESCALE   = 1,
    parameter int SEL_BIT    = 8
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [31:0]           i_dbus_adr,
    input  logic [31:0]           i_dbus_dat,
    input  logic [3:0]            i_dbus_sel,
    input  logic                  i_dbus_we,
    input  logic                  i_dbus_cyc,
    output logic [31:0]           o_dbus_rdt,
    output logic                  o_dbus_ack,
    input  logic [GPIO_IN_W-1:0]  i_gpio_in,
    output logic [GPIO_OUT_W-1:0] o_gpio_out,
    output logic                  o_timer_irq
);

    logic                  acc;
    logic                  wr_acc;
    logic                  rd_acc;
    reg_off_e              off;
    logic [GPIO_OUT_W-1:0] gpio_out;
    logic [GPIO_IN_W-1:0]  gpio_meta;
    logic [GPIO_IN_W-1:0]  gpio_sync;
    logic [CTRL_W-1:0]     ctrl;
    logic [31:0]           gpio_out_ext;
    logic [31:0]           ctrl_ext;
    logic [31:0]           mtime_rd;
    logic [31:0]           mtimecmp_rd;
    logic [31:0]           rdata;
    logic                  unused_adr;

    // A transaction is taken once; the ack cycle itself blocks re-acceptance,
    // so a held cyc produces one access every other cycle.
    assign acc        = i_dbus_cyc && i_dbus_adr[SEL_BIT] && !o_dbus_ack;
    assign wr_acc     = acc && i_dbus_we;
    assign rd_acc     = acc && !i_dbus_we;
    assign off        = reg_off_e'(i_dbus_adr[4:2]);
    assign unused_adr = ^{i_dbus_adr[31:5], i_dbus_adr[1:0]};

    assign o_gpio_out = (OUT_INV != 0) ? ~gpio_out : gpio_out;

    // Read mux: everything zero-extended, unmapped offsets read zero.
    always_comb begin
        gpio_out_ext                 = '0;
        gpio_out_ext[GPIO_OUT_W-1:0] = gpio_out;
        ctrl_ext                     = '0;
        ctrl_ext[CTRL_W-1:0]         = ctrl;
        rdata                        = '0;
        case (off)
            REG_GPIO_OUT: rdata                  = gpio_out_ext;
            REG_GPIO_IN:  rdata[GPIO_IN_W-1:0]   = gpio_sync;
            REG_MTIME:    rdata                  = mtime_rd;
            REG_MTIMECMP: rdata                  = mtimecmp_rd;
            REG_CTRL:     rdata                  = ctrl_ext;
            default:      rdata                  = '0;
        endcase
    end

    // Acknowledge one cycle after accept; read data only moves on read accepts.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_dbus_ack <= 1'b0;
            o_dbus_rdt <= '0;
        end else begin
            o_dbus_ack <= acc;
            if (rd_acc) o_dbus_rdt <= rdata;
        end
    end

    // GPIO output register with byte-lane writes.
    always_ff @(posedge clk) begin
        if (i_rst)
            gpio_out <= '0;
        else if (wr_acc && off == REG_GPIO_OUT)
            gpio_out <= GPIO_OUT_W'(merge_bytes(gpio_out_ext, i_dbus_dat, i_dbus_sel));
    end

    // CTRL register: timer enable and irq enable.
    always_ff @(posedge clk) begin
        if (i_rst)
            ctrl <= '0;
        else if (wr_acc && off == REG_CTRL)
            ctrl <= CTRL_W'(merge_bytes(ctrl_ext, i_dbus_dat, i_dbus_sel));
    end

    // Two-flop synchroniser for the asynchronous input pins.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            gpio_meta <= '0;
            gpio_sync <= '0;
        end else begin
            gpio_meta <= i_gpio_in;
            gpio_sync <= gpio_meta;
        end
    end

    serv_periph_timer #(
        .TIMER_W  (TIMER_W),
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_en          (ctrl[CTRL_TIMER_EN]),
        .i_irq_en      (ctrl[CTRL_IRQ_EN]),
        .i_mtime_we    (wr_acc && off == REG_MTIME),
        .i_mtimecmp_we (wr_acc && off == REG_MTIMECMP),
        .i_wdat        (i_dbus_dat),
        .i_wsel        (i_dbus_sel),
        .o_mtime       (mtime_rd),
        .o_mtimecmp    (mtimecmp_rd),
        .o_irq         (o_timer_irq)
    );

endmodule

// File: tb/tb_serv_periph.sv
// Self-checking bench for serv_periph: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// behavioural model of the register map.
module tb_serv_periph;

    localparam int GOW = 3;
    localparam int GIW = 2;
    localparam int TW  = 8;
    localparam int PS  = 4;
    localparam int SB  = 8;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam logic [31:0] TMASK = 32'h0000_00FF;
    localparam logic [31:0] GMASK = 32'h0000_0007;

    logic           clk = 1'b0;
    logic           i_rst;
    logic [31:0]    i_dbus_adr;
    logic [31:0]    i_dbus_dat;
    logic [3:0]     i_dbus_sel;
    logic           i_dbus_we;
    logic           i_dbus_cyc;
    logic [31:0]    o_dbus_rdt;
    logic           o_dbus_ack;
    logic [GIW-1:0] i_gpio_in;
    logic [GOW-1:0] o_gpio_out;
    logic           o_timer_irq;

    always #5 clk = ~clk;

    serv_periph #(
        .GPIO_OUT_W (GOW),
        .GPIO_IN_W  (GIW),
        .OUT_INV    (1),
        .TIMER_W    (TW),
        .PRESCALE   (PS),
        .SEL_BIT    (SB)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_dbus_adr  (i_dbus_adr),
        .i_dbus_dat  (i_dbus_dat),
        .i_dbus_sel  (i_dbus_sel),
        .i_dbus_we   (i_dbus_we),
        .i_dbus_cyc  (i_dbus_cyc),
        .o_dbus_rdt  (o_dbus_rdt),
        .o_dbus_ack  (o_dbus_ack),
        .i_gpio_in   (i_gpio_in),
        .o_gpio_out  (o_gpio_out),
        .o_timer_irq (o_timer_irq)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: register contents and expected output values.
    // mtime is base + (enabled cycles since last write or reset) / PRESCALE.
    logic        m_ack;
    logic        m_irq;
    logic [31:0] m_rdt, m_gpio, m_cmp, m_ctrl, m_base, m_pin1, m_pin2;
    int unsigned m_en_cyc;

    function automatic logic [31:0] wmerge(input logic [31:0] cur, input logic [31:0] d,
                                           input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (cur & ~m) | (d & m);
    endfunction

    function automatic logic [31:0] m_mtime();
        return (m_base + m_en_cyc / PS) & TMASK;
    endfunction

    // Advance the model by one clock edge using the inputs applied at that edge.
    task automatic model_step();
        logic [31:0] mt_now;
        logic        acc;
        logic        irq_nx;
        int          off;
        mt_now = m_mtime();
        if (i_rst) begin
            m_ack = 0; m_rdt = 0; m_gpio = 0; m_cmp = TMASK; m_ctrl = 0;
            m_base = 0; m_en_cyc = 0; m_pin1 = 0; m_pin2 = 0; m_irq = 0;
            return;
        end
        acc    = i_dbus_cyc && i_dbus_adr[SB] && !m_ack;
        off    = int'(i_dbus_adr[4:2]);
        irq_nx = m_ctrl[1] && (mt_now >= m_cmp);
        if (acc && !i_dbus_we) begin
            case (off)
                0:       m_rdt = m_gpio;
                1:       m_rdt = m_pin2;
                2:       m_rdt = mt_now;
                3:       m_rdt = m_cmp;
                4:       m_rdt = m_ctrl;
                default: m_rdt = 0;
            endcase
        end
        m_pin2 = m_pin1;
        m_pin1 = 32'(i_gpio_in);
        if (m_ctrl[0]) m_en_cyc++;
        if (acc && i_dbus_we) begin
            case (off)
                0: m_gpio = wmerge(m_gpio, i_dbus_dat, i_dbus_sel) & GMASK;
                2: begin
                    m_base   = wmerge(mt_now, i_dbus_dat, i_dbus_sel) & TMASK;
                    m_en_cyc = 0;
                end
                3: m_cmp  = wmerge(m_cmp, i_dbus_dat, i_dbus_sel) & TMASK;
                4: m_ctrl = wmerge(m_ctrl, i_dbus_dat, i_dbus_sel) & 32'h3;
                default: ;
            endcase
        end
        m_ack = acc;
        m_irq = irq_nx;
    endtask

    // Single compare process: all outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ack",      32'(o_dbus_ack),  32'(m_ack));
            check("rdt",      o_dbus_rdt,       m_rdt);
            check("gpio_out", 32'(o_gpio_out),  ~m_gpio & GMASK);
            check("irq",      32'(o_timer_irq), 32'(m_irq));
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic bus(input logic wr, input logic [2:0] off, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdat);
        i_dbus_cyc = 1'b1;
        i_dbus_we  = wr;
        i_dbus_adr = BASE | {27'd0, off, 2'b00};
        i_dbus_dat = dat;
        i_dbus_sel = sel;
        step();
        check("bus_ack", 32'(o_dbus_ack), 32'd1);
        rdat = o_dbus_rdt;
        i_dbus_cyc = 1'b0;
        i_dbus_we  = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] r;
        logic [5:0]  pat;
        int          k;

        i_rst = 1; i_dbus_cyc = 0; i_dbus_we = 0; i_dbus_adr = 0;
        i_dbus_dat = 0; i_dbus_sel = 0; i_gpio_in = 0;
        step(); step();
        chk_en = 1'b1;
        check("rst_ack",  32'(o_dbus_ack),  32'd0);
        check("rst_rdt",  o_dbus_rdt,       32'd0);
        check("rst_pins", 32'(o_gpio_out),  32'h7);
        check("rst_irq",  32'(o_timer_irq), 32'd0);
        i_rst = 0;
        step();

        // GPIO_OUT write / readback with inverted pins
        bus(1, 3'd0, 32'h5, 4'hF, r);
        check("gpio_pins_5", 32'(o_gpio_out), 32'h2);
        bus(0, 3'd0, 32'h0, 4'hF, r);
        check("gpio_readback", r, 32'h5);

        // input synchroniser: old value one cycle after change, new after two
        i_gpio_in = 2'b01;
        step();
        bus(0, 3'd1, 32'h0, 4'hF, r);
        check("gpio_in_early", r, 32'h0);
        bus(0, 3'd1, 32'h0, 4'hF, r);
        check("gpio_in_synced", r, 32'h1);

        // unmapped offset acks, ignores the write, reads zero
        bus(1, 3'd6, 32'hFFFF_FFFF, 4'hF, r);
        bus(0, 3'd6, 32'h0, 4'hF, r);
        check("unmapped_read", r, 32'h0);

        // byte enables and truncation on the 8-bit mtimecmp
        bus(1, 3'd3, 32'h1234_5678, 4'b0010, r);
        bus(0, 3'd3, 32'h0, 4'hF, r);
        check("cmp_lane1_only", r, 32'hFF);
        bus(1, 3'd3, 32'h1234_5678, 4'b0001, r);
        bus(0, 3'd3, 32'h0, 4'hF, r);
        check("cmp_lane0", r, 32'h78);

        // held cyc: ack every other cycle, one write per ack
        i_dbus_cyc = 1; i_dbus_we = 1; i_dbus_adr = BASE; i_dbus_sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            i_dbus_dat = 32'(i + 1);
            pat[i] = o_dbus_ack;
            step();
        end
        i_dbus_cyc = 0; i_dbus_we = 0;
        step();
        check("held_cyc_ack_pattern", 32'(pat), 32'b101010);
        check("held_cyc_last_write", 32'(o_gpio_out), 32'h2);

        // reset on the accept edge aborts the write
        i_dbus_cyc = 1; i_dbus_we = 1; i_dbus_adr = BASE; i_dbus_dat = 32'h5; i_dbus_sel = 4'hF;
        i_rst = 1;
        step();
        check("rst_abort_ack0", 32'(o_dbus_ack), 32'd0);
        i_rst = 0; i_dbus_cyc = 0; i_dbus_we = 0;
        step();
        check("rst_abort_ack1", 32'(o_dbus_ack), 32'd0);
        check("rst_abort_pins", 32'(o_gpio_out), 32'h7);

        // irq rises 13 cycles after enabling with PRESCALE=4, mtimecmp=3
        bus(1, 3'd3, 32'h3, 4'hF, r);
        bus(1, 3'd4, 32'h3, 4'hF, r);
        k = 1;
        while (!o_timer_irq && k < 60) begin
            step();
            k++;
        end
        check("irq_rise_cycles", 32'(k), 32'd13);
        bus(1, 3'd3, 32'hFFFF_FFFF, 4'hF, r);
        check("irq_clear_cmp", 32'(o_timer_irq), 32'd0);

        // 8-bit mtime wraps from 0xFF to 0 and drops the irq
        i_rst = 1; step(); i_rst = 0; step();
        bus(1, 3'd3, 32'h80, 4'hF, r);
        bus(1, 3'd4, 32'h3, 4'hF, r);
        bus(1, 3'd2, 32'hFF, 4'hF, r);
        check("irq_at_ff", 32'(o_timer_irq), 32'd1);
        step(); step(); step();
        check("irq_before_wrap", 32'(o_timer_irq), 32'd1);
        step();
        check("irq_after_wrap", 32'(o_timer_irq), 32'd0);
        bus(0, 3'd2, 32'h0, 4'hF, r);
        check("mtime_wrapped", r, 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            i_rst      = ($urandom_range(0, 299) == 0);
            i_dbus_cyc = ($urandom_range(0, 3) != 0);
            i_dbus_we  = $urandom_range(0, 1) == 1;
            i_dbus_adr = $urandom;
            i_dbus_adr[SB] = ($urandom_range(0, 7) != 0);
            i_dbus_dat = $urandom;
            if ($urandom_range(0, 3) == 0) i_dbus_dat = $urandom_range(0, 7);
            i_dbus_sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) i_gpio_in = 2'($urandom_range(0, 3));
            step();
        end
        i_rst = 0; i_dbus_cyc = 0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
